// File: rtl/ram_reader.sv
// ram_reader
//   Sweeps S-RAM addresses 0..DEPTH-1 in ascending order after a start request.
//   It tags each read with a latency-matched valid pipeline and queues the returned
//   bytes in a small FIFO. The bytes leave on a valid/ready stream. When CHECK_ID is
//   set, each accepted byte is compared against its own address (the identity
//   permutation S[i]==i). The first mismatch is latched.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   start       in   level request; a run begins on its rising edge while idle,
//                    and dropping it mid-run aborts the run
//   address     out  RAM read address (low 8 bits of the read pointer)
//   ram_out     in   RAM read data, valid READ_LATENCY clocks after the address
//   data_out    out  streamed byte, S[i] in ascending i
//   data_valid  out  data_out holds a byte
//   data_ready  in   consumer accepts on data_valid && data_ready at a clock edge
//   finished    out  all DEPTH bytes accepted; held while start stays high
//   error       out  sticky identity-check failure flag
//   error_addr  out  address of the first mismatching byte
module ram_reader #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 1,
    parameter bit CHECK_ID     = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] address,
    input  logic [7:0] ram_out,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       finished,
    output logic       error,
    output logic [7:0] error_addr
);

    localparam int         FIFO_DEPTH = READ_LATENCY + 1;
    localparam logic [8:0] LAST_PTR   = 9'(DEPTH);
    localparam logic [3:0] CAPACITY   = 4'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] count_ones(input logic [3:0] bits);
        logic [3:0] total;
        total = 4'd0;
        for (int i = 0; i < 4; i++) begin
            total = total + {3'b000, bits[i]};
        end
        return total;
    endfunction

    function automatic logic id_mismatch(input logic [7:0] data, input logic [7:0] addr);
        return (data != addr);
    endfunction

    state_t                           state_r;
    state_t                           state_s;
    logic                             start_q_r;
    logic [8:0]                       rd_ptr_r;
    logic [READ_LATENCY-1:0]          pipe_vld_r;
    logic [READ_LATENCY-1:0][7:0]     pipe_addr_r;
    logic [FIFO_DEPTH-1:0]            fifo_vld_r;
    logic [FIFO_DEPTH-1:0][7:0]       fifo_data_r;
    logic [FIFO_DEPTH-1:0][7:0]       fifo_addr_r;
    logic [FIFO_DEPTH-1:0]            shift_vld_s;
    logic [FIFO_DEPTH-1:0][7:0]       shift_data_s;
    logic [FIFO_DEPTH-1:0][7:0]       shift_addr_s;
    logic [FIFO_DEPTH-1:0]            fifo_vld_s;
    logic [FIFO_DEPTH-1:0][7:0]       fifo_data_s;
    logic [FIFO_DEPTH-1:0][7:0]       fifo_addr_s;
    logic                             finished_r;
    logic                             error_r;
    logic [7:0]                       error_addr_r;

    logic                             start_rise_s;
    logic                             pop_s;
    logic                             ret_vld_s;
    logic [7:0]                       ret_addr_s;
    logic [3:0]                       inflight_s;
    logic [3:0]                       fifo_cnt_s;
    logic [3:0]                       occupancy_s;
    logic [3:0]                       wr_idx_s;
    logic                             abort_s;
    logic                             issue_s;

    assign start_rise_s = start & ~start_q_r;
    assign pop_s        = fifo_vld_r[0] & data_ready;
    assign ret_vld_s    = pipe_vld_r[READ_LATENCY-1];
    assign ret_addr_s   = pipe_addr_r[READ_LATENCY-1];
    assign inflight_s   = count_ones({{(4-READ_LATENCY){1'b0}}, pipe_vld_r});
    assign fifo_cnt_s   = count_ones({{(4-FIFO_DEPTH){1'b0}}, fifo_vld_r});
    // The byte leaving the FIFO this clock frees its slot. Crediting it keeps
    // one byte per clock flowing with only READ_LATENCY+1 entries, and the
    // FIFO plus in-flight reads still never exceed capacity.
    assign occupancy_s  = fifo_cnt_s + inflight_s - {3'b000, pop_s};
    assign wr_idx_s     = fifo_cnt_s - {3'b000, pop_s};
    assign abort_s      = ((state_r == ST_READ) || (state_r == ST_DRAIN)) && !start;
    assign issue_s      = (state_r == ST_READ) && start && (rd_ptr_r < LAST_PTR) &&
                          (occupancy_s < CAPACITY);

    // Next-state selection for the sweep controller.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    state_s = ST_READ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!start) begin
                    state_s = ST_IDLE;
                end else if (rd_ptr_r == LAST_PTR) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (!start) begin
                    state_s = ST_IDLE;
                end else if ((inflight_s == 4'd0) && (fifo_cnt_s == 4'd0)) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (!start) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register, start edge detector and finished flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            start_q_r  <= 1'b0;
            finished_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            start_q_r  <= start;
            finished_r <= (state_s == ST_DONE);
        end
    end

    // Read pointer: restarts at 0 on a new run and advances once per issued read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_r <= 9'd0;
        end else if ((state_r == ST_IDLE) && start_rise_s) begin
            rd_ptr_r <= 9'd0;
        end else if (issue_s) begin
            rd_ptr_r <= rd_ptr_r + 9'd1;
        end
    end

    // Issue-valid shift register; its last stage marks ram_out as a live return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_vld_r  <= '0;
            pipe_addr_r <= '0;
        end else if (abort_s) begin
            pipe_vld_r  <= '0;
        end else begin
            pipe_vld_r[0]  <= issue_s;
            pipe_addr_r[0] <= rd_ptr_r[7:0];
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_addr_r[i] <= pipe_addr_r[i-1];
            end
        end
    end

    // FIFO entries after an optional pop: everything moves one slot toward the head.
    always_comb begin
        shift_vld_s  = fifo_vld_r;
        shift_data_s = fifo_data_r;
        shift_addr_s = fifo_addr_r;
        if (pop_s) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
                shift_vld_s[i]  = fifo_vld_r[i+1];
                shift_data_s[i] = fifo_data_r[i+1];
                shift_addr_s[i] = fifo_addr_r[i+1];
            end
            shift_vld_s[FIFO_DEPTH-1] = 1'b0;
        end else begin
            shift_vld_s  = fifo_vld_r;
            shift_data_s = fifo_data_r;
            shift_addr_s = fifo_addr_r;
        end
    end

    // FIFO next contents: the returning byte lands right behind the last kept entry.
    always_comb begin
        fifo_vld_s  = shift_vld_s;
        fifo_data_s = shift_data_s;
        fifo_addr_s = shift_addr_s;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_vld_s[i]  = abort_s ? 1'b0 :
                             ((ret_vld_s && (wr_idx_s == 4'(i))) ? 1'b1 : shift_vld_s[i]);
            fifo_data_s[i] = (ret_vld_s && (wr_idx_s == 4'(i))) ? ram_out : shift_data_s[i];
            fifo_addr_s[i] = (ret_vld_s && (wr_idx_s == 4'(i))) ? ret_addr_s : shift_addr_s[i];
        end
    end

    // FIFO storage; slot 0 is the head and drives the output port directly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_vld_r  <= '0;
            fifo_data_r <= '0;
            fifo_addr_r <= '0;
        end else begin
            fifo_vld_r  <= fifo_vld_s;
            fifo_data_r <= fifo_data_s;
            fifo_addr_r <= fifo_addr_s;
        end
    end

    // Identity check: only the first mismatching accepted byte is recorded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_r      <= 1'b0;
            error_addr_r <= 8'd0;
        end else if ((state_r == ST_IDLE) && start_rise_s) begin
            error_r      <= 1'b0;
            error_addr_r <= 8'd0;
        end else if (CHECK_ID && pop_s && !error_r &&
                     id_mismatch(fifo_data_r[0], fifo_addr_r[0])) begin
            error_r      <= 1'b1;
            error_addr_r <= fifo_addr_r[0];
        end
    end

    assign address    = rd_ptr_r[7:0];
    assign data_out   = fifo_data_r[0];
    assign data_valid = fifo_vld_r[0];
    assign finished   = finished_r;
    assign error      = error_r;
    assign error_addr = error_addr_r;

endmodule

// File: tb/tb_ram_reader.sv
// tb_ram_reader
//   Drives two ram_reader instances: index 0 with READ_LATENCY=1 and index 1 with
//   READ_LATENCY=2. Each instance reads from a RAM model that shares one memory
//   array. The expected stream is mem[0..255] in order. The expected error is the
//   first accepted index whose byte differs from the index.
module tb_ram_reader;

    localparam int N = 256;

    logic       clk;
    logic       reset;
    logic       start_a    [2];
    logic       ready_a    [2];
    logic [7:0] address_a  [2];
    logic [7:0] data_out_a [2];
    logic       valid_a    [2];
    logic       fin_a      [2];
    logic       err_a      [2];
    logic [7:0] eaddr_a    [2];

    logic [7:0] mem [0:N-1];
    logic [7:0] ram_q0;
    logic [7:0] ram_q1a;
    logic [7:0] ram_q1b;

    int n_vec;
    int n_miss;

    ram_reader #(.DEPTH(N), .READ_LATENCY(1), .CHECK_ID(1'b1)) dut0 (
        .clk(clk), .reset(reset), .start(start_a[0]), .address(address_a[0]),
        .ram_out(ram_q0), .data_out(data_out_a[0]), .data_valid(valid_a[0]),
        .data_ready(ready_a[0]), .finished(fin_a[0]), .error(err_a[0]),
        .error_addr(eaddr_a[0])
    );

    ram_reader #(.DEPTH(N), .READ_LATENCY(2), .CHECK_ID(1'b1)) dut1 (
        .clk(clk), .reset(reset), .start(start_a[1]), .address(address_a[1]),
        .ram_out(ram_q1b), .data_out(data_out_a[1]), .data_valid(valid_a[1]),
        .data_ready(ready_a[1]), .finished(fin_a[1]), .error(err_a[1]),
        .error_addr(eaddr_a[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM models, one and two clocks of latency.
    always @(posedge clk) begin
        ram_q0  <= mem[address_a[0]];
        ram_q1a <= mem[address_a[1]];
        ram_q1b <= ram_q1a;
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill_identity();
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
    endtask

    // mode: 0 ready always high, 1 ready toggles, 2 random ready, 3 ten-clock stall at byte 5
    task automatic sweep(input int sel, input int mode, input int max_acc, input int stop_addr);
        int k, cyc, post, stall_cnt, exp_eaddr;
        bit seen, exp_err, stalled, done, rdy, v;
        k = 0; cyc = 0; post = 0; stall_cnt = 0; exp_eaddr = 0;
        seen = 1'b0; exp_err = 1'b0; stalled = 1'b0; done = 1'b0;
        @(negedge clk);
        start_a[sel] = 1'b1;
        while (!done) begin
            @(negedge clk);
            cyc++;
            v = valid_a[sel];
            check_val("error", int'(err_a[sel]), int'(exp_err));
            check_val("error_addr", int'(eaddr_a[sel]), exp_eaddr);
            if (cyc > 3000) begin
                check_val("timeout", cyc, 3000);
                done = 1'b1;
            end else if (k == max_acc) begin
                done = 1'b1;
            end else if ((stop_addr >= 0) && (address_a[sel] == 8'(stop_addr))) begin
                done = 1'b1;
            end else if (k == N) begin
                post++;
                if (post == 1) begin
                    check_val("tail_valid", int'(v), 0);
                    check_val("finished_late", int'(fin_a[sel]), 0);
                end else begin
                    check_val("finished", int'(fin_a[sel]), 1);
                    done = 1'b1;
                end
            end else begin
                check_val("finished_early", int'(fin_a[sel]), 0);
                if (v) begin
                    check_val("data", int'(data_out_a[sel]), int'(mem[k]));
                    if (!seen) check_val("first_latency", cyc, sel + 3);
                    seen = 1'b1;
                end else begin
                    if (stalled) check_val("hold_valid", int'(v), 1);
                    if ((mode == 0) && seen) check_val("gap", int'(v), 1);
                end
                case (mode)
                    0: rdy = 1'b1;
                    1: rdy = (cyc % 2) == 1;
                    2: rdy = ($urandom_range(0, 3) != 0);
                    default: begin
                        if ((k == 5) && (stall_cnt < 10)) begin
                            rdy = 1'b0;
                            stall_cnt++;
                        end else begin
                            rdy = 1'b1;
                        end
                    end
                endcase
                ready_a[sel] = rdy;
                if (v && rdy) begin
                    if ((mem[k] != 8'(k)) && !exp_err) begin
                        exp_err = 1'b1;
                        exp_eaddr = k;
                    end
                    k++;
                end
                stalled = v && !rdy;
            end
        end
    endtask

    task automatic end_run(input int sel);
        @(negedge clk);
        check_val("finished_hold", int'(fin_a[sel]), 1);
        start_a[sel] = 1'b0;
        ready_a[sel] = 1'b0;
        @(negedge clk);
        check_val("finished_clear", int'(fin_a[sel]), 0);
    endtask

    task automatic check_reset_vals(input int sel);
        check_val("rst_address", int'(address_a[sel]), 0);
        check_val("rst_data_out", int'(data_out_a[sel]), 0);
        check_val("rst_valid", int'(valid_a[sel]), 0);
        check_val("rst_finished", int'(fin_a[sel]), 0);
        check_val("rst_error", int'(err_a[sel]), 0);
        check_val("rst_error_addr", int'(eaddr_a[sel]), 0);
    endtask

    initial begin
        n_vec = 0;
        n_miss = 0;
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            start_a[s] = 1'b0;
            ready_a[s] = 1'b0;
        end
        fill_identity();
        repeat (2) @(negedge clk);
        check_reset_vals(0);
        check_reset_vals(1);
        reset = 1'b0;
        @(negedge clk);

        // 1) identity RAM, ready always high
        sweep(0, 0, N, -1);
        end_run(0);

        // 2) ready toggling every clock
        sweep(0, 1, N, -1);
        end_run(0);

        // 3) two planted mismatches, random backpressure
        mem[8'h37] = 8'h00;
        mem[8'h90] = 8'h11;
        sweep(0, 2, N, -1);
        end_run(0);

        // 3b) random mismatch positions and values
        fill_identity();
        for (int j = 0; j < 4; j++) mem[$urandom_range(0, N - 1)] = 8'($urandom);
        sweep(0, 2, N, -1);
        end_run(0);

        // 4) abort after 100 accepted bytes, then a fresh sweep from 0
        fill_identity();
        sweep(0, 0, 100, -1);
        start_a[0] = 1'b0;
        ready_a[0] = 1'b0;
        @(negedge clk);
        check_val("abort_valid", int'(valid_a[0]), 0);
        check_val("abort_finished", int'(fin_a[0]), 0);
        sweep(0, 2, N, -1);
        end_run(0);

        // 5) asynchronous reset at address 0x80 while the error flag is set
        mem[8'h37] = 8'h00;
        sweep(0, 0, N, 8'h80);
        #2 reset = 1'b1;
        #1 check_reset_vals(0);
        start_a[0] = 1'b0;
        ready_a[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        fill_identity();
        sweep(0, 2, N, -1);
        end_run(0);

        // 6) READ_LATENCY=2 with a ten-clock stall at byte 5, then random traffic
        sweep(1, 3, N, -1);
        end_run(1);
        for (int j = 0; j < 3; j++) mem[$urandom_range(0, N - 1)] = 8'($urandom);
        sweep(1, 2, N, -1);
        end_run(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
